// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access path: access sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // Reserved size 11 is rejected the same way as an unaligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: extract/extend a load lane from a RAM word, and merge
// a sub-word store into the old RAM word.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shamt = '0;
    mask  = '1;
    // Big-endian byte 0 lives in the top lane, so the offset is mirrored.
    case (size)
      SZ_BYTE: begin
        shamt = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
        mask  = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase

    lane = ram_word >> shamt;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & lane[7]}}, lane[7:0]};
      SZ_HALF: load_data = {{16{is_signed & lane[15]}}, lane[15:0]};
      default: load_data = ram_word;
    endcase

    merged = (ram_word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Core data-port to word-wide data_ram adapter: sub-word loads, read-modify-write
// sub-word stores, misalignment rejection and core stall.
//   state   | meaning
//   IDLE    | accept request; word store writes here, misaligned rejected here
//   LD_WAIT | ram_dout valid, return extended load data
//   ST_RD   | ram_dout valid, latch merged word
//   ST_WR   | write merged word
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t      state;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        bad;

  // Upper address bits wrap into the RAM.
  logic [31-RAM_AW-2:0] unused_addr_hi;
  assign unused_addr_hi = req_addr[31:RAM_AW+2];

  assign ram_addr = req_addr[RAM_AW+1:2];
  assign bad      = is_misaligned(req_size, req_addr[1:0]);

  mem_access_unit_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size      (req_size),
    .offset    (req_addr[1:0]),
    .is_signed (req_signed),
    .ram_word  (ram_dout),
    .wdata     (req_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !bad) begin
            if (!req_wen)                state <= LD_WAIT;
            else if (req_size != SZ_WORD) state <= ST_RD;
          end
        end
        LD_WAIT: begin
          rdata_q <= load_data;
          state   <= IDLE;
        end
        ST_RD: begin
          merge_q <= merged;
          state   <= ST_WR;
        end
        ST_WR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so a reset mid-store can never write the RAM.
  always_comb begin
    req_stall   = 1'b0;
    rdata_valid = 1'b0;
    misalign    = 1'b0;
    ram_we      = 1'b0;
    ram_din     = '0;
    rdata       = rdata_q;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (bad) begin
              misalign = 1'b1;
            end else if (req_wen && req_size == SZ_WORD) begin
              ram_we  = 1'b1;
              ram_din = req_wdata;
            end else begin
              req_stall = 1'b1;
            end
          end
        end
        LD_WAIT: begin
          rdata       = load_data;
          rdata_valid = 1'b1;
        end
        ST_RD: req_stall = 1'b1;
        ST_WR: begin
          ram_we  = 1'b1;
          ram_din = merge_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: little- and big-endian instances driven in lockstep against behavioural RAMs,
// with a byte-array reference model and load-result scoreboards.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_init;
  logic        req_valid, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic          stall_le, stall_be, rv_le, rv_be, mis_le, mis_be, we_le, we_be;
  logic [31:0]   rdata_le, rdata_be, din_le, din_be, dout_le, dout_be;
  logic [AW-1:0] addr_le, addr_be;

  logic [31:0] ram_le [1024];
  logic [31:0] ram_be [1024];
  logic [31:0] shadow_le [1024];
  logic [31:0] shadow_be [1024];

  logic [31:0] sb_le[$];
  logic [31:0] sb_be[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_AW(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_stall(stall_le), .rdata(rdata_le), .rdata_valid(rv_le), .misalign(mis_le),
    .ram_we(we_le), .ram_addr(addr_le), .ram_din(din_le), .ram_dout(dout_le)
  );

  mem_access_unit #(.RAM_AW(AW), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_stall(stall_be), .rdata(rdata_be), .rdata_valid(rv_be), .misalign(mis_be),
    .ram_we(we_be), .ram_addr(addr_be), .ram_din(din_be), .ram_dout(dout_be)
  );

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 1024; i++) begin
        ram_le[i] <= 32'h0;
        ram_be[i] <= 32'h0;
      end
      ram_le[8]  <= 32'h80FF7F01; ram_be[8]  <= 32'h80FF7F01;
      ram_le[12] <= 32'h11223344; ram_be[12] <= 32'h11223344;
      ram_le[20] <= 32'h11223344; ram_be[20] <= 32'h11223344;
      ram_le[24] <= 32'hCAFEF00D; ram_be[24] <= 32'hCAFEF00D;
    end else begin
      if (we_le) ram_le[addr_le] <= din_le;
      if (we_be) ram_be[addr_be] <= din_be;
    end
    dout_le <= ram_le[addr_le];
    dout_be <= ram_be[addr_be];
  end

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_le;
    bit          le_k;
    logic [31:0] exp_be;
    bit          be_k;
    logic        mis;
    int          stall;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_load(bit be, logic [31:0] w, logic [1:0] size,
                                         logic [1:0] off, logic sgn);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = be ? w[8*(3-i) +: 8] : w[8*i +: 8];
    case (size)
      SZ_BYTE: return sgn ? {{24{b[off][7]}}, b[off]} : {24'h0, b[off]};
      SZ_HALF: begin
        h = be ? {b[off], b[off+1]} : {b[off+1], b[off]};
        return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(bit be, logic [31:0] w, logic [1:0] size,
                                          logic [1:0] off, logic [31:0] wd);
    logic [7:0]  b [4];
    logic [31:0] r;
    if (size == SZ_WORD) return wd;
    for (int i = 0; i < 4; i++) b[i] = be ? w[8*(3-i) +: 8] : w[8*i +: 8];
    if (size == SZ_BYTE) b[off] = wd[7:0];
    else if (be) begin b[off] = wd[15:8]; b[off+1] = wd[7:0]; end
    else begin b[off] = wd[7:0]; b[off+1] = wd[15:8]; end
    r = '0;
    for (int i = 0; i < 4; i++) r[(be ? 8*(3-i) : 8*i) +: 8] = b[i];
    return r;
  endfunction

  task automatic issue(input vec_t v, input logic [31:0] e_le, input logic [31:0] e_be,
                       input string name);
    int stalls = 0, wes_le = 0, wes_be = 0, mis_n = 0;
    logic [31:0] wd_le = '0, wd_be = '0, wa = '0;
    bit done = 0;
    if (!v.wen && !v.mis) begin
      sb_le.push_back(e_le);
      sb_be.push_back(e_be);
    end
    @(negedge clk);
    req_valid = 1'b1; req_wen = v.wen; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (stall_le) stalls++;
      if (mis_le)   mis_n++;
      if (we_le) begin wes_le++; wd_le = din_le; wa = 32'(addr_le); end
      if (we_be) begin wes_be++; wd_be = din_be; end
      if (rv_le) begin
        if (sb_le.size() == 0) chk({name, " rdata_valid_le"}, 32'd1, 32'd0);
        else chk({name, " rdata_le"}, rdata_le, sb_le.pop_front());
      end
      if (rv_be) begin
        if (sb_be.size() == 0) chk({name, " rdata_valid_be"}, 32'd1, 32'd0);
        else chk({name, " rdata_be"}, rdata_be, sb_be.pop_front());
      end
      if (!stall_le && !stall_be) begin done = 1; break; end
      @(negedge clk);
    end
    chk({name, " completed"}, 32'(done), 32'd1);
    chk({name, " stall_cycles"}, 32'(stalls), 32'(v.stall));
    chk({name, " misalign"}, 32'(mis_n), v.mis ? 32'd1 : 32'd0);
    chk({name, " ram_we_le"}, 32'(wes_le), (v.wen && !v.mis) ? 32'd1 : 32'd0);
    chk({name, " ram_we_be"}, 32'(wes_be), (v.wen && !v.mis) ? 32'd1 : 32'd0);
    if (v.wen && !v.mis) begin
      chk({name, " ram_din_le"}, wd_le, e_le);
      chk({name, " ram_din_be"}, wd_be, e_be);
      chk({name, " ram_addr"}, wa, 32'(v.addr[AW+1:2]));
    end
    chk({name, " load_pending"}, 32'(sb_le.size() + sb_be.size()), 32'd0);
    sb_le.delete();
    sb_be.delete();
  endtask

  task automatic run(input vec_t v, input string name);
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   m_le, m_be;
    idx  = v.addr[AW+1:2];
    off  = v.addr[1:0];
    m_le = v.wen ? m_store(0, shadow_le[idx], v.size, off, v.wdata)
                 : m_load(0, shadow_le[idx], v.size, off, v.sgn);
    m_be = v.wen ? m_store(1, shadow_be[idx], v.size, off, v.wdata)
                 : m_load(1, shadow_be[idx], v.size, off, v.sgn);
    if (v.wen && !v.mis) begin
      shadow_le[idx] = m_le;
      shadow_be[idx] = m_be;
    end
    issue(v, v.le_k ? v.exp_le : m_le, v.be_k ? v.exp_be : m_be, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      shadow_le[i] = 32'h0;
      shadow_be[i] = 32'h0;
    end
    shadow_le[8]  = 32'h80FF7F01; shadow_be[8]  = 32'h80FF7F01;
    shadow_le[12] = 32'h11223344; shadow_be[12] = 32'h11223344;
    shadow_le[20] = 32'h11223344; shadow_be[20] = 32'h11223344;
    shadow_le[24] = 32'hCAFEF00D; shadow_be[24] = 32'hCAFEF00D;

    //               wen size     sgn addr          wdata          exp_le        le_k exp_be       be_k mis stall
    tab.push_back('{1, SZ_WORD, 0, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 1, 32'h0,        0, 0, 0});
    tab.push_back('{0, SZ_BYTE, 1, 32'h21,   32'h0,        32'h0000007F, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_BYTE, 1, 32'h23,   32'h0,        32'hFFFFFF80, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_BYTE, 0, 32'h23,   32'h0,        32'h00000080, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_HALF, 1, 32'h22,   32'h0,        32'hFFFF80FF, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_HALF, 0, 32'h20,   32'h0,        32'h00007F01, 1, 32'h0,        0, 0, 1});
    tab.push_back('{1, SZ_BYTE, 0, 32'h31,   32'hAA,       32'h1122AA44, 1, 32'h0,        0, 0, 2});
    tab.push_back('{1, SZ_HALF, 0, 32'h32,   32'hBEEF,     32'hBEEFAA44, 1, 32'h0,        0, 0, 2});
    tab.push_back('{0, SZ_WORD, 0, 32'h30,   32'h0,        32'hBEEFAA44, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_HALF, 0, 32'h41,   32'h0,        32'h0,        0, 32'h0,        0, 1, 0});
    tab.push_back('{0, SZ_WORD, 0, 32'h42,   32'h0,        32'h0,        0, 32'h0,        0, 1, 0});
    tab.push_back('{0, 2'b11,   0, 32'h40,   32'h0,        32'h0,        0, 32'h0,        0, 1, 0});
    tab.push_back('{1, SZ_HALF, 0, 32'h43,   32'h5555,     32'h0,        0, 32'h0,        0, 1, 0});
    tab.push_back('{1, SZ_WORD, 0, 32'h1014, 32'h12345678, 32'h12345678, 1, 32'h0,        0, 0, 0});
    tab.push_back('{0, SZ_WORD, 0, 32'h14,   32'h0,        32'h12345678, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_WORD, 0, 32'h10,   32'h0,        32'hDEADBEEF, 1, 32'h0,        0, 0, 1});
    tab.push_back('{0, SZ_BYTE, 0, 32'h50,   32'h0,        32'h0,        0, 32'h00000011, 1, 0, 1});
    tab.push_back('{1, SZ_BYTE, 0, 32'h53,   32'hAA,       32'h0,        0, 32'h112233AA, 1, 0, 2});
    tab.push_back('{0, SZ_WORD, 0, 32'h50,   32'h0,        32'h0,        0, 32'h112233AA, 1, 0, 1});

    rst = 1'b1; do_init = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; do_init = 1'b0;
    #1;
    chk("reset req_stall", 32'(stall_le), 32'd0);
    chk("reset rdata", rdata_le, 32'h0);
    chk("reset rdata_valid", 32'(rv_le), 32'd0);
    chk("reset misalign", 32'(mis_le), 32'd0);
    chk("reset ram_we", 32'({we_le, we_be}), 32'd0);

    foreach (tab[i]) run(tab[i], $sformatf("vec%0d", i));

    // Reset while a byte store sits in ST_RD must abort without writing.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h61; req_wdata = 32'h55;
    #1;
    chk("rst_abort stall_idle", 32'(stall_le), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_abort ram_we_during_rst", 32'({we_le, we_be}), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_abort req_stall", 32'({stall_le, stall_be}), 32'd0);
    chk("rst_abort rdata", rdata_le, 32'h0);
    chk("rst_abort rdata_valid", 32'({rv_le, rv_be}), 32'd0);
    chk("rst_abort misalign", 32'({mis_le, mis_be}), 32'd0);
    chk("rst_abort ram_we", 32'({we_le, we_be}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_abort ram_word_le", ram_le[24], 32'hCAFEF00D);
    chk("rst_abort ram_word_be", ram_be[24], 32'hCAFEF00D);
    run('{0, SZ_WORD, 0, 32'h60, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 0, 1}, "post_rst_lw");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
